// File: rtl/shuffle_engine_if.sv
// Control and user storage port bundle for shuffle_engine.
// The master side is user logic and the slave side is the engine.
interface shuffle_engine_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int LFSR_W = 16
);
  logic              start;
  logic [ADDR_W-1:0] len_1;
  logic              seed_load;
  logic [LFSR_W-1:0] seed_val;
  logic [ADDR_W-1:0] usr_r_addr;
  logic [ADDR_W-1:0] usr_w_addr;
  logic [DATA_W-1:0] usr_din;
  logic              usr_wr_en;
  logic [DATA_W-1:0] dout;
  logic              busy;
  logic              done;

  modport master (
    output start, len_1, seed_load, seed_val,
    output usr_r_addr, usr_w_addr, usr_din, usr_wr_en,
    input  dout, busy, done
  );

  modport slave (
    input  start, len_1, seed_load, seed_val,
    input  usr_r_addr, usr_w_addr, usr_din, usr_wr_en,
    output dout, busy, done
  );
endinterface

// File: rtl/shuffle_engine.sv
// In-place Fisher-Yates shuffler over a private register file, driven by a Galois LFSR.
// Rejection sampling keeps the choice of swap index unbiased.
module shuffle_engine #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int LFSR_W = 16,
  parameter logic [LFSR_W-1:0] SEED = LFSR_W'(16'hACE1)
) (
  input  logic            clk,
  input  logic            rst_n,
  shuffle_engine_if.slave bus
);
  localparam int DEPTH = 2**ADDR_W;

  // Maximal-length toggle masks for a right-shifting Galois LFSR.
  function automatic logic [63:0] tap_table(input int w);
    case (w)
      3:       return 64'h6;
      4:       return 64'hC;
      5:       return 64'h14;
      6:       return 64'h30;
      7:       return 64'h60;
      8:       return 64'hB8;
      9:       return 64'h110;
      10:      return 64'h240;
      11:      return 64'h500;
      12:      return 64'hE08;
      13:      return 64'h1C80;
      14:      return 64'h3802;
      15:      return 64'h6000;
      16:      return 64'hB400;
      17:      return 64'h12000;
      18:      return 64'h20400;
      19:      return 64'h72000;
      20:      return 64'h90000;
      21:      return 64'h140000;
      22:      return 64'h300000;
      23:      return 64'h420000;
      24:      return 64'hE10000;
      32:      return 64'h80200003;
      default: return 64'hB400;
    endcase
  endfunction

  localparam logic [63:0]       TAP_FULL = tap_table(LFSR_W);
  localparam logic [LFSR_W-1:0] TAPS     = TAP_FULL[LFSR_W-1:0];

  // Smear the leading one down to bit 0, giving the tightest power-of-two-minus-one cover of v.
  function automatic logic [ADDR_W-1:0] fill_mask(input logic [ADDR_W-1:0] v);
    logic [ADDR_W-1:0] m;
    m = v;
    for (int k = 0; k < ADDR_W; k++) m = m | (m >> 1);
    return m;
  endfunction

  typedef enum logic [2:0] {
    S_IDLE,
    S_PICK,
    S_LOAD,
    S_WJ,
    S_WI,
    S_DONE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] i;
  logic [ADDR_W-1:0] j;
  logic [ADDR_W-1:0] mask;
  logic [DATA_W-1:0] temp;
  logic [LFSR_W-1:0] lfsr;
  logic              busy;
  logic              done;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] mem_r_addr;
  logic [ADDR_W-1:0] mem_w_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] rd_data;
  logic              mem_we;

  logic [LFSR_W-1:0] lfsr_next;
  logic [LFSR_W-1:0] seed_eff;
  logic [ADDR_W-1:0] pick;
  logic [ADDR_W-1:0] i_dec;

  assign lfsr_next = {1'b0, lfsr[LFSR_W-1:1]} ^ (lfsr[0] ? TAPS : '0);
  assign seed_eff  = (bus.seed_val == '0) ? SEED : bus.seed_val;
  assign pick      = lfsr[ADDR_W-1:0] & mask;
  assign i_dec     = i - 1'b1;

  // While busy the FSM owns the storage and the user write strobe is dropped.
  always_comb begin
    mem_r_addr = bus.usr_r_addr;
    mem_w_addr = bus.usr_w_addr;
    mem_we     = bus.usr_wr_en;
    if (busy) begin
      mem_r_addr = (state == S_LOAD) ? j : i;
      mem_w_addr = (state == S_WJ) ? j : i;
      mem_we     = (state == S_WJ) || (state == S_WI);
    end
  end

  assign rd_data = mem[mem_r_addr];

  always_comb begin
    mem_din = bus.usr_din;
    if (busy) mem_din = (state == S_WJ) ? rd_data : temp;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_w_addr] <= mem_din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      i     <= '0;
      j     <= '0;
      mask  <= '0;
      temp  <= '0;
      lfsr  <= SEED;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      lfsr <= lfsr_next;
      case (state)
        S_IDLE: begin
          if (bus.seed_load) lfsr <= seed_eff;
          if (bus.start) begin
            i    <= bus.len_1;
            mask <= fill_mask(bus.len_1);
            busy <= 1'b1;
            if (bus.len_1 == '0) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              state <= S_PICK;
            end
          end
        end
        S_PICK: begin
          // Out-of-range draws are rejected and retried next cycle with a fresh LFSR value.
          if (pick <= i) begin
            j     <= pick;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          temp  <= rd_data;
          state <= S_WJ;
        end
        S_WJ: begin
          state <= S_WI;
        end
        S_WI: begin
          i    <= i_dec;
          mask <= fill_mask(i_dec);
          if (i == ADDR_W'(1)) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            state <= S_PICK;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.dout = rd_data;
  assign bus.busy = busy;
  assign bus.done = done;
endmodule

// File: doc/shuffle_engine.md
# shuffle_engine

Parametrised in-place Fisher-Yates shuffler: owns a DEPTH-entry register file and permutes entries 0..len_1 uniformly using an on-block LFSR and rejection sampling. It generalises the fixed 8-bit/32-entry scrambler in data width, depth and LFSR width, and adds:

- asynchronous reset
- a done pulse
- seed loading
- unbiased index selection

While idle, user logic fills and reads the storage through the user port.

## Interface

Parameters:
- DATA_W, 8, width of each storage entry
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W
- LFSR_W, 16, LFSR width; must be ≥ ADDR_W
- SEED, 16'hACE1, LFSR reset/fallback value (LFSR_W bits, nonzero)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin shuffle; sampled only in IDLE
- len_1  in  ADDR_W  index of last entry to shuffle; captured on accepted start
- seed_load  in  1  load seed_val into LFSR; honoured only in IDLE
- seed_val  in  LFSR_W  new seed; all-zero value is replaced by SEED
- usr_r_addr  in  ADDR_W  user read address
- usr_w_addr  in  ADDR_W  user write address
- usr_din  in  DATA_W  user write data
- usr_wr_en  in  1  user write strobe; ignored while busy
- dout  out  DATA_W  combinational read data, mem[r_addr]
- busy  out  1  shuffle in progress; router selects internal port
- done  out  1  one-cycle pulse on shuffle completion

## Operation

- **Storage:** DEPTH x DATA_W flops. One write per cycle, combinational read. Not reset.
- **Router:**
  - busy=0: storage ports come from usr_*.
  - busy=1: storage ports come from the FSM; usr_wr_en is dropped.
- **LFSR:**
  - Galois, right shift, advances every cycle including IDLE.
  - LFSR_W=16 taps mask 16'hB400; other widths use a maximal-length mask from the team tap table.
  - seed_load in IDLE overrides the advance that cycle.
- **Registers:** i (ADDR_W), j (ADDR_W), temp (DATA_W), mask (ADDR_W).
  - mask = all ones from bit 0 through the MSB of i, e.g. i=5 → 3'b111, i=1 → 1.
- **FSM states:**
  - IDLE: on start, i<=len_1. Go to DONE if len_1==0, else PICK.
  - PICK:
    - r = lfsr[ADDR_W-1:0] & mask.
    - r ≤ i: j<=r, go to LOAD.
    - r > i: stay in PICK (rejection).
  - LOAD: r_addr=j; temp<=dout.
  - WJ: r_addr=i, w_addr=j, din=dout, write.
  - WI: w_addr=i, din=temp, write. i<=i-1. Go to DONE if i==1, else PICK.
  - DONE: done=1, go to IDLE.
- j==i is legal: swap writes identical data back.
- start while busy and start coincident with seed_load: seed applied, start accepted; first PICK uses the new seed's next state.

## Timing

- **Reset values:** state IDLE; busy 0; done 0; i, j, temp, mask 0; LFSR SEED. dout follows mem[usr_r_addr], contents undefined after power-up.
- **Start accepted at edge N:**
  - busy=1 from cycle N+1 through the DONE cycle inclusive.
  - done=1 only in the DONE cycle.
  - IDLE at the following edge; a new start is accepted there.
- **Latency:** 1 + Σ(PICK cycles per i) + 3·len_1 cycles from accept to last busy cycle.
  - Minimum 4·len_1+1.
  - len_1=0: busy and done for exactly 1 cycle, no writes.
- PICK per step is geometrically bounded; acceptance probability is > 1/2 each cycle.
- **User write:** takes effect at the edge where usr_wr_en=1 and busy=0. Read-after-write is visible the next cycle.
- **dout during busy:** reflects internal addresses and is not meaningful to the user.
- **rst_n low mid-shuffle:**
  - Immediate return to IDLE, busy=0, no done pulse.
  - Storage keeps its contents; these may be a non-permutation if reset lands after WJ.

## Test plan

- **Reset:** assert rst_n=0 mid-operation → busy=0, done=0 asynchronously; LFSR reads 16'hACE1 one cycle after release.
- **User port:** write mem[k]=k for k=0..31, read back → dout=k each address; len_1=0 start → busy=done=1 for exactly one cycle, contents unchanged.
- **Full shuffle:**
  - Stimulus: mem[k]=k, len_1=31, default seed.
  - Required: done pulses after ≥125 cycles; readback is a permutation of 0..31.
  - Required: result bit-identical to the bench's reference model of the LFSR/rejection algorithm.
- **Partial shuffle:** len_1=7 with mem[k]=k → entries 8..31 unchanged, entries 0..7 a permutation of 0..7.
- **Lockout and determinism:**
  - usr_wr_en=1 to address 3 with 8'hFF during busy, plus a second start → neither the write nor the second start has any effect.
  - seed_load 16'h1234 then shuffle, repeated twice from the same initial contents → identical outputs. seed_val=0 behaves as SEED.
- **Parameter sweep:** DATA_W=16, ADDR_W=3, len_1=7 → valid permutation, done pulse, busy low the cycle after done.
